// File: rtl/i2s_in.sv
// i2s_in: I2S receiver (bus slave).
// Samples an externally driven BCLK/WS/SD into the clk_in domain and recovers
// left/right PCM words, MSB first, one BCLK after each WS change.
//
// Ports:
//   clk_in          system clock; must run at 4x BCLK or faster
//   reset_in        asynchronous, active-high reset
//   bclk_in         I2S bit clock (asynchronous to clk_in)
//   ws_in           I2S word select: 0 = left, 1 = right
//   sd_in           I2S serial data
//   data_out        most recently completed word
//   channel_out     slot of data_out: 0 = left, 1 = right
//   data_valid_out  one-cycle strobe: data_out/channel_out valid
//   left_out        held left word of the last complete frame
//   right_out       held right word of the last complete frame
//   frame_valid_out one-cycle strobe: left_out/right_out updated as a pair
//   length_err_out  one-cycle strobe with data_valid_out when the slot length
//                   differs from DATA_WIDTH
//
// SYNC_STAGES must be at least 2.
module i2s_in #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  bclk_in,
  input  logic                  ws_in,
  input  logic                  sd_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  channel_out,
  output logic                  data_valid_out,
  output logic [DATA_WIDTH-1:0] left_out,
  output logic [DATA_WIDTH-1:0] right_out,
  output logic                  frame_valid_out,
  output logic                  length_err_out
);

  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  // All three pins share the same synchroniser depth so WS/SD stay aligned
  // with the BCLK edge they were launched against.
  logic [SYNC_STAGES-1:0] r_bclk_sync;
  logic [SYNC_STAGES-1:0] r_ws_sync;
  logic [SYNC_STAGES-1:0] r_sd_sync;
  logic                   r_bclk_prev;

  logic [DATA_WIDTH-1:0]  r_acc;
  logic [5:0]             r_bit_cnt;
  logic                   r_ws_last;
  logic                   r_locked;
  logic [DATA_WIDTH-1:0]  r_pend_left;
  logic                   r_pend_ok;

  logic                   w_bclk_s;
  logic                   w_ws_s;
  logic                   w_sd_s;
  logic                   w_bit_edge;
  logic                   w_in_range;
  logic [IW-1:0]          w_idx;
  logic [DATA_WIDTH-1:0]  w_word;
  logic                   w_len_err;

  assign w_bclk_s   = r_bclk_sync[SYNC_STAGES-1];
  assign w_ws_s     = r_ws_sync[SYNC_STAGES-1];
  assign w_sd_s     = r_sd_sync[SYNC_STAGES-1];
  assign w_bit_edge = w_bclk_s & ~r_bclk_prev;

  // Current bit position (MSB first) and the word as it stands including the
  // bit sampled on this edge; w_idx is only meaningful when w_in_range.
  always_comb begin
    w_in_range = (int'(r_bit_cnt) < DATA_WIDTH);
    w_idx      = IW'(DATA_WIDTH - 1 - int'(r_bit_cnt));
    w_word     = r_acc;
    if (w_in_range) w_word[w_idx] = w_sd_s;
    w_len_err  = ((int'(r_bit_cnt) + 1) != DATA_WIDTH);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      r_bclk_sync     <= '0;
      r_ws_sync       <= '0;
      r_sd_sync       <= '0;
      r_bclk_prev     <= 1'b0;
      r_acc           <= '0;
      r_bit_cnt       <= '0;
      r_ws_last       <= 1'b0;
      r_locked        <= 1'b0;
      r_pend_left     <= '0;
      r_pend_ok       <= 1'b0;
      data_out        <= '0;
      channel_out     <= 1'b0;
      data_valid_out  <= 1'b0;
      left_out        <= '0;
      right_out       <= '0;
      frame_valid_out <= 1'b0;
      length_err_out  <= 1'b0;
    end else begin
      r_bclk_sync     <= {r_bclk_sync[SYNC_STAGES-2:0], bclk_in};
      r_ws_sync       <= {r_ws_sync[SYNC_STAGES-2:0], ws_in};
      r_sd_sync       <= {r_sd_sync[SYNC_STAGES-2:0], sd_in};
      r_bclk_prev     <= w_bclk_s;
      data_valid_out  <= 1'b0;
      frame_valid_out <= 1'b0;
      length_err_out  <= 1'b0;

      if (w_bit_edge) begin
        if (w_ws_s == r_ws_last) begin
          // Mid-slot: bits past DATA_WIDTH are dropped, counter saturates.
          if (w_in_range) r_acc[w_idx] <= w_sd_s;
          if (r_bit_cnt != 6'd63) r_bit_cnt <= r_bit_cnt + 6'd1;
        end else begin
          // WS change: this edge carries the LSB of the slot that just ended.
          // Before lock the slot may be partial, so it is discarded.
          if (r_locked) begin
            data_out       <= w_word;
            channel_out    <= r_ws_last;
            data_valid_out <= 1'b1;
            length_err_out <= w_len_err;
            if (!r_ws_last) begin
              r_pend_left <= w_word;
              r_pend_ok   <= 1'b1;
            end else if (r_pend_ok) begin
              left_out        <= r_pend_left;
              right_out       <= w_word;
              frame_valid_out <= 1'b1;
              r_pend_ok       <= 1'b0;
            end
          end
          r_acc     <= '0;
          r_bit_cnt <= '0;
          r_ws_last <= w_ws_s;
          r_locked  <= 1'b1;
        end
      end
    end
  end

endmodule
